// File: rtl/alu_spi_master_if.sv
// Request/response handshake plus SPI pins for the ALU SPI master.
//   master : view taken by alu_spi_master (drives nss/mosi, owns req_ready/rsp_*)
//   slave  : view taken by whoever feeds requests, consumes results and models the SPI slave
// Signals:
//   req_valid/req_ready/req_opcode/req_opa/req_opb : request channel
//   rsp_valid/rsp_ready/rsp_data                   : response channel
//   busy                                           : master is mid-transaction
//   spi_nss/spi_mosi/spi_miso                      : serial link, bit clock = system clock
interface alu_spi_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_opcode;
  logic [31:0] req_opa;
  logic [31:0] req_opb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic        spi_nss;
  logic        spi_mosi;
  logic        spi_miso;

  modport master (
    input  req_valid, req_opcode, req_opa, req_opb, rsp_ready, spi_miso,
    output req_ready, rsp_valid, rsp_data, busy, spi_nss, spi_mosi
  );

  modport slave (
    output req_valid, req_opcode, req_opa, req_opb, rsp_ready, spi_miso,
    input  req_ready, rsp_valid, rsp_data, busy, spi_nss, spi_mosi
  );
endinterface

// File: rtl/alu_spi_master.sv
// SPI master for the 4-op ALU slave. Takes one request, sends a 66-bit
// command frame {opcode, opa, opb} MSB first, waits GAP_CYCLES with nss high,
// then opens a response frame and shifts in the 32-bit result MSB first.
// One bit per system clock; no separate sclk.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : alu_spi_master_if.master (request, response, busy, SPI pins)
// Parameters:
//   CMD_LEAD   : cycles from nss falling to first mosi bit
//   GAP_CYCLES : nss-high cycles between frames (1..255)
//   RSP_LEAD   : cycles from nss falling to first miso sample (0..15)
//
// state       | meaning
// ------------+---------------------------------------------------------
// S_IDLE      | waiting for a request, req_ready high, nss high
// S_CMD_LEAD  | nss low, mosi 0, counting down the command lead-in
// S_CMD_SHIFT | driving the 66 command bits, one per cycle
// S_GAP       | nss high while the slave computes
// S_RSP_LEAD  | nss low, counting down before the first miso sample
// S_RSP_SHIFT | sampling 32 result bits from miso
// S_DONE      | result presented, waiting for rsp_ready
module alu_spi_master #(
  parameter int unsigned CMD_LEAD   = 2,
  parameter int unsigned GAP_CYCLES = 8,
  parameter int unsigned RSP_LEAD   = 3
) (
  input  logic             clock,
  input  logic             reset,
  alu_spi_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD_LEAD,
    S_CMD_SHIFT,
    S_GAP,
    S_RSP_LEAD,
    S_RSP_SHIFT,
    S_DONE
  } state_t;

  // Timer reload values; the timers are down-counters that expire at zero,
  // so a lead/gap of N cycles reloads with N-1.
  localparam logic [7:0] CMD_LEAD_M1 = 8'(CMD_LEAD - 1);
  localparam logic [7:0] GAP_M1      = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] RSP_LEAD_M1 = 8'(RSP_LEAD - 1);

  state_t      state;
  logic [65:0] frame;
  logic [6:0]  bit_cnt;
  logic [7:0]  tmr;
  logic [31:0] shreg;

  logic        req_ready_r;
  logic        busy_r;
  logic        nss_r;
  logic        mosi_r;
  logic        rsp_valid_r;
  logic [31:0] rsp_data_r;

  assign bus.req_ready = req_ready_r;
  assign bus.busy      = busy_r;
  assign bus.spi_nss   = nss_r;
  assign bus.spi_mosi  = mosi_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      frame       <= '0;
      bit_cnt     <= '0;
      tmr         <= '0;
      shreg       <= '0;
      req_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      nss_r       <= 1'b1;
      mosi_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            nss_r       <= 1'b0;
            if (CMD_LEAD == 0) begin
              // No lead-in: the first bit goes out on the edge that drops nss,
              // so the frame is stored already shifted past it.
              mosi_r  <= bus.req_opcode[1];
              frame   <= {bus.req_opcode[0], bus.req_opa, bus.req_opb, 1'b0};
              bit_cnt <= 7'd65;
              state   <= S_CMD_SHIFT;
            end else begin
              frame <= {bus.req_opcode, bus.req_opa, bus.req_opb};
              tmr   <= CMD_LEAD_M1;
              state <= S_CMD_LEAD;
            end
          end
        end

        S_CMD_LEAD: begin
          if (tmr == 8'd0) begin
            mosi_r  <= frame[65];
            frame   <= {frame[64:0], 1'b0};
            bit_cnt <= 7'd65;
            state   <= S_CMD_SHIFT;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        // bit_cnt = bits still to send after the one currently on mosi
        S_CMD_SHIFT: begin
          if (bit_cnt == 7'd0) begin
            nss_r  <= 1'b1;
            mosi_r <= 1'b0;
            tmr    <= GAP_M1;
            state  <= S_GAP;
          end else begin
            mosi_r  <= frame[65];
            frame   <= {frame[64:0], 1'b0};
            bit_cnt <= bit_cnt - 7'd1;
          end
        end

        S_GAP: begin
          if (tmr == 8'd0) begin
            nss_r <= 1'b0;
            if (RSP_LEAD == 0) begin
              bit_cnt <= 7'd31;
              state   <= S_RSP_SHIFT;
            end else begin
              tmr   <= RSP_LEAD_M1;
              state <= S_RSP_LEAD;
            end
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        S_RSP_LEAD: begin
          if (tmr == 8'd0) begin
            bit_cnt <= 7'd31;
            state   <= S_RSP_SHIFT;
          end else begin
            tmr <= tmr - 8'd1;
          end
        end

        S_RSP_SHIFT: begin
          shreg <= {shreg[30:0], bus.spi_miso};
          if (bit_cnt == 7'd0) begin
            nss_r       <= 1'b1;
            rsp_data_r  <= {shreg[30:0], bus.spi_miso};
            rsp_valid_r <= 1'b1;
            state       <= S_DONE;
          end else begin
            bit_cnt <= bit_cnt - 7'd1;
          end
        end

        S_DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
